mem_port_arbiter_way0: RTL

- Shares one 64-bit memory port between two way0 requesters: the instruction fetch path (PCU/IFU) and the data load/store path (FU register/FetchUnit).
- Replaces the separate instruction-side and data-side memories in BnineCore_way0 with a single sequenced port.
- Handles one outstanding transaction at a time.
- Data accesses have priority, with a starvation limit for fetch.
- Fetch responses are discarded when a jump flushes the front end.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_select_way0.sv | 79 +++++++
 rtl/mem_port_arbiter_way0.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the way0 memory port arbiter.
// State/owner encodings plus the instruction word selector used on fetch responses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    localparam logic [2:0] WSTATE_DONE = 3'b111;

    // Wide enough for the largest legal starvation limit (15).
    localparam int CNT_W = 4;

    // Pick the 32-bit instruction out of a 64-bit beat using address bit 2.
    function automatic logic [31:0] select_inst(input logic        hi_word,
                                                input logic [63:0] beat);
        return hi_word ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_arb_select_way0.sv
// Winner selection between fetch and data requesters, with starvation counter.
// Build with ARB_ROUND_ROBIN_EN defined to replace the counter by a strict alternation pointer.
module mem_arb_select_way0
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   arb_en_i,
    input  logic   if_req_i,
    input  logic   if_flush_i,
    input  logic   d_req_i,
    output logic   grant_o,
    output owner_e owner_o
);

    logic if_elig;

    // A jump flush in the arbitration cycle removes fetch from contention.
    assign if_elig = if_req_i & ~if_flush_i;
    assign grant_o = arb_en_i & (if_elig | d_req_i);

`ifdef ARB_ROUND_ROBIN_EN

    logic prefer_d_q;
    logic prefer_d_d;

    assign owner_o = (if_elig && (!d_req_i || !prefer_d_q)) ? OWN_IF : OWN_D;

    always_comb begin
        prefer_d_d = prefer_d_q;
        if (grant_o) begin
            prefer_d_d = (owner_o == OWN_IF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_d_q <= 1'b1;
        end else begin
            prefer_d_q <= prefer_d_d;
        end
    end

`else

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign owner_o = (if_elig && (!d_req_i || cnt_q == STARVE_LIM)) ? OWN_IF : OWN_D;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i) begin
            cnt_d = '0;
        end else if (grant_o) begin
            if (owner_o == OWN_IF) begin
                cnt_d = '0;
            end else if (cnt_q != STARVE_LIM) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`endif

endmodule

// File: rtl/mem_port_arbiter_way0.sv
// Single 64-bit memory port shared by way0 instruction fetch and data load/store.
// One transaction in flight; arbitration policy selectable via ARB_ROUND_ROBIN_EN.
module mem_port_arbiter_way0
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_ok_o,
    output logic [31:0]         if_inst_o,

    input  logic                d_rd_i,
    input  logic                d_wr_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wmask_i,
    output logic                d_ok_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic [2:0]          d_wstate_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    state_e              state_q;
    owner_e              owner_q;
    logic                drop_q;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_wmask_q;

    logic                if_ok_q;
    logic [31:0]         if_inst_q;
    logic                d_ok_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic [2:0]          d_wstate_q;

    logic                grant;
    owner_e              sel_owner;
    logic                if_flushed;

    mem_arb_select_way0 #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk        (clk),
        .reset      (reset),
        .arb_en_i   (state_q == IDLE),
        .if_req_i   (if_req_i),
        .if_flush_i (if_flush_i),
        .d_req_i    (d_rd_i | d_wr_i),
        .grant_o    (grant),
        .owner_o    (sel_owner)
    );

    // A flush seen at any point of an in-flight fetch kills its response.
    assign if_flushed = (owner_q == OWN_IF) && (drop_q || if_flush_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            if_ok_q     <= 1'b0;
            if_inst_q   <= '0;
            d_ok_q      <= 1'b0;
            d_rdata_q   <= '0;
            d_wstate_q  <= '0;
        end else begin
            if_ok_q    <= 1'b0;
            d_ok_q     <= 1'b0;
            d_wstate_q <= '0;

            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q   <= sel_owner;
                        drop_q    <= 1'b0;
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
                        if (sel_owner == OWN_IF) begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr_i;
                            mem_wdata_q <= '0;
                            mem_wmask_q <= '0;
                        end else begin
                            // Write wins over a simultaneous read; the read is granted later.
                            mem_we_q    <= d_wr_i;
                            mem_addr_q  <= d_addr_i;
                            mem_wdata_q <= d_wr_i ? d_wdata_i : '0;
                            mem_wmask_q <= d_wr_i ? d_wmask_i : '0;
                        end
                    end
                end

                REQ: begin
                    if (if_flushed) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end

                WAIT: begin
                    if (if_flushed) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        state_q <= RESP;
                        if (owner_q == OWN_IF) begin
                            if (!if_flushed) begin
                                if_ok_q   <= 1'b1;
                                if_inst_q <= select_inst(mem_addr_q[2], mem_rdata_i[63:0]);
                            end
                        end else if (mem_we_q) begin
                            d_wstate_q <= WSTATE_DONE;
                        end else begin
                            d_ok_q    <= 1'b1;
                            d_rdata_q <= mem_rdata_i;
                        end
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_ok_o     = if_ok_q;
    assign if_inst_o   = if_inst_q;
    assign d_ok_o      = d_ok_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_wstate_o  = d_wstate_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;

endmodule
